prime_checker_seq: RTL

- Parametrised iterative primality tester for unsigned WIDTH-bit operands.
- Uses valid/ready handshakes on input and result; one operand in flight at a time.
- Tests trial divisors 3, 5, 7, 11, 13, … (3, then 6k±1).
- Each remainder comes from a shared bit-serial divider, so there is no wide combinational modulo.
- Reports primality and the smallest nontrivial factor; used as a standalone number-theory accelerator.

---
 rtl/prime_pkg.sv | 22 ++
 rtl/prime_mod_seq.sv | 82 ++++++++
 rtl/prime_checker_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// Shared types and constants for the iterative primality tester.
// The 6k+-1 divisor walk is described by FIRST_DIV and the two step sizes.
package prime_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV,
        STEP,
        DONE
    } state_e;

    localparam logic [2:0] FIRST_DIV  = 3'd3;
    localparam logic [2:0] STEP_SMALL = 3'd2;
    localparam logic [2:0] STEP_LARGE = 3'd4;

    // Increment that takes the current trial divisor to the next one.
    function automatic logic [2:0] nextDivStep(input logic largeStep);
        return largeStep ? STEP_LARGE : STEP_SMALL;
    endfunction

endpackage

// File: rtl/prime_mod_seq.sv
// Restoring bit-serial remainder unit: rem_o = dividend mod divisor.
// done_o pulses for one cycle exactly WIDTH cycles after start_i.
module prime_mod_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [WIDTH-1:0] restoreStep(input logic [WIDTH-1:0] r,
                                                     input logic             b,
                                                     input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] t;
        t = {r, b};
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
        end
        return t[WIDTH-1:0];
    endfunction

    // The first quotient bit is resolved on the start edge so the result lands WIDTH cycles later.
    always_comb begin
        rem_d     = rem_q;
        shift_d   = shift_q;
        divisor_d = divisor_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (start_i) begin
            rem_d     = restoreStep('0, dividend_i[WIDTH-1], divisor_i);
            shift_d   = {dividend_i[WIDTH-2:0], 1'b0};
            divisor_d = divisor_i;
            count_d   = CNT_INIT;
            busy_d    = 1'b1;
        end else if (busy_q) begin
            rem_d   = restoreStep(rem_q, shift_q[WIDTH-1], divisor_q);
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            rem_q     <= rem_d;
            shift_q   <= shift_d;
            divisor_q <= divisor_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign done_o = done_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/prime_checker_seq.sv
// Iterative primality tester with valid/ready handshakes and trial division by 3, then 6k+-1.
// Optional cycle counter output enabled with PRIME_CYCLE_COUNT_EN.
module prime_checker_seq
    import prime_pkg::*;
#(
    parameter int WIDTH = 16
`ifdef PRIME_CYCLE_COUNT_EN
    ,
    parameter int CNT_W = 24
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_is_prime_o,
    output logic [WIDTH-1:0] out_factor_o
`ifdef PRIME_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_cycles_o
`endif
);

    localparam int SQ_W = 2 * WIDTH + 2;
    localparam logic [WIDTH:0] DIV_INIT = (WIDTH + 1)'(FIRST_DIV);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH:0]   d_q, d_d;
    logic             large_q, large_d;
    logic             outValid_q, outValid_d;
    logic             isPrime_q, isPrime_d;
    logic [WIDTH-1:0] factor_q, factor_d;

    logic [WIDTH:0]   dNext;
    logic [SQ_W-1:0]  dNextSq;
    logic             divStart;
    logic [WIDTH-1:0] divDivisor;
    logic             divDone;
    logic [WIDTH-1:0] divRem;

    prime_mod_seq #(
        .WIDTH(WIDTH)
    ) u_mod (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_i   (divStart),
        .dividend_i(n_q),
        .divisor_i (divDivisor),
        .done_o    (divDone),
        .rem_o     (divRem)
    );

    // Results are captured on DONE entry; out_valid follows one cycle later and holds until taken.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        d_d        = d_q;
        large_d    = large_q;
        outValid_d = outValid_q;
        isPrime_d  = isPrime_q;
        factor_d   = factor_q;
        divStart   = 1'b0;
        divDivisor = d_q[WIDTH-1:0];
        dNext      = d_q + (WIDTH + 1)'(nextDivStep(large_q));
        dNextSq    = SQ_W'(dNext) * SQ_W'(dNext);
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    n_d     = in_data_i;
                    d_d     = DIV_INIT;
                    large_d = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (n_q < WIDTH'(2)) begin
                    isPrime_d = 1'b0;
                    factor_d  = '0;
                    state_d   = DONE;
                end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
                    isPrime_d = 1'b1;
                    factor_d  = n_q;
                    state_d   = DONE;
                end else if (!n_q[0]) begin
                    isPrime_d = 1'b0;
                    factor_d  = WIDTH'(2);
                    state_d   = DONE;
                end else begin
                    divStart = 1'b1;
                    state_d  = DIV;
                end
            end
            DIV: begin
                if (divDone) begin
                    if (divRem == '0) begin
                        isPrime_d = 1'b0;
                        factor_d  = d_q[WIDTH-1:0];
                        state_d   = DONE;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                // A surviving d_next never exceeds sqrt(N), so it fits the WIDTH-bit divider port.
                if (dNextSq > SQ_W'(n_q)) begin
                    isPrime_d = 1'b1;
                    factor_d  = n_q;
                    state_d   = DONE;
                end else begin
                    d_d        = dNext;
                    large_d    = (d_q == DIV_INIT) ? 1'b0 : ~large_q;
                    divStart   = 1'b1;
                    divDivisor = dNext[WIDTH-1:0];
                    state_d    = DIV;
                end
            end
            DONE: begin
                if (!outValid_q) begin
                    outValid_d = 1'b1;
                end else if (out_ready_i) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            d_q        <= DIV_INIT;
            large_q    <= 1'b0;
            outValid_q <= 1'b0;
            isPrime_q  <= 1'b0;
            factor_q   <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            d_q        <= d_d;
            large_q    <= large_d;
            outValid_q <= outValid_d;
            isPrime_q  <= isPrime_d;
            factor_q   <= factor_d;
        end
    end

`ifdef PRIME_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycles_q;

    // Counts every busy cycle up to and including the DONE-entry edge, saturating at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycles_q <= '0;
        end else if (state_q == IDLE && in_valid_i) begin
            cycles_q <= '0;
        end else if ((state_q == CHECK || state_q == DIV || state_q == STEP) && cycles_q != '1) begin
            cycles_q <= cycles_q + CNT_W'(1);
        end
    end

    assign out_cycles_o = cycles_q;
`endif

    assign in_ready_o     = (state_q == IDLE);
    assign out_valid_o    = outValid_q;
    assign out_is_prime_o = isPrime_q;
    assign out_factor_o   = factor_q;

endmodule
